// File: rtl/arm_id_stage.sv
// ARM instruction-decode stage: decodes one instruction per cycle, evaluates its
// condition against NZCV and registers control/operand fields into the ID/EX register.
module arm_id_stage #(
   parameter int CMD_W  = 4,
   parameter int REG_AW = 4,
   parameter int PC_W   = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [3:0]        flags,
   input  logic              stall,
   input  logic              flush,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [CMD_W-1:0]  exe_cmd,
   output logic              mem_read,
   output logic              mem_write,
   output logic              wb_en,
   output logic              branch,
   output logic              s_upd,
   output logic              rn_valid,
   output logic              src2_valid,
   output logic              imm,
   output logic [REG_AW-1:0] rn,
   output logic [REG_AW-1:0] rd,
   output logic [REG_AW-1:0] src2,
   output logic [11:0]       shift_op,
   output logic [23:0]       imm24,
   output logic [PC_W-1:0]   out_pc,
   output logic              undef,
   output logic [CNT_W-1:0]  squash_cnt
);

   logic [1:0] mode;
   logic [3:0] op;
   logic       s_bit;
   assign mode  = instr[27:26];
   assign op    = instr[24:21];
   assign s_bit = instr[20];

   logic [3:0] cmd4_d;
   logic       mem_read_d, mem_write_d, wb_en_d, branch_d, s_upd_d;
   logic       rn_valid_d, src2_valid_d, src2_rd_d, undef_d;
   logic       cond_pass;

   always_comb begin
      // NOTE: every output gets a default before the case, so no path can infer a latch.
      cmd4_d       = 4'b0000;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      wb_en_d      = 1'b0;
      branch_d     = 1'b0;
      s_upd_d      = 1'b0;
      rn_valid_d   = 1'b0;
      src2_valid_d = 1'b0;
      src2_rd_d    = 1'b0;
      undef_d      = 1'b0;
      case (mode)
         2'b00: begin
            case (op)
               4'b1101: begin cmd4_d = 4'b0001; wb_en_d = 1'b1; s_upd_d = s_bit; end
               4'b1111: begin cmd4_d = 4'b1001; wb_en_d = 1'b1; s_upd_d = s_bit; end
               4'b0100: begin cmd4_d = 4'b0010; wb_en_d = 1'b1; s_upd_d = s_bit; rn_valid_d = 1'b1; end
               4'b0101: begin cmd4_d = 4'b0011; wb_en_d = 1'b1; s_upd_d = s_bit; rn_valid_d = 1'b1; end
               4'b0010: begin cmd4_d = 4'b0100; wb_en_d = 1'b1; s_upd_d = s_bit; rn_valid_d = 1'b1; end
               4'b0110: begin cmd4_d = 4'b0101; wb_en_d = 1'b1; s_upd_d = s_bit; rn_valid_d = 1'b1; end
               4'b0000: begin cmd4_d = 4'b0110; wb_en_d = 1'b1; s_upd_d = s_bit; rn_valid_d = 1'b1; end
               4'b1100: begin cmd4_d = 4'b0111; wb_en_d = 1'b1; s_upd_d = s_bit; rn_valid_d = 1'b1; end
               4'b0001: begin cmd4_d = 4'b1000; wb_en_d = 1'b1; s_upd_d = s_bit; rn_valid_d = 1'b1; end
               4'b1010: begin cmd4_d = 4'b0100; s_upd_d = 1'b1; rn_valid_d = 1'b1; end
               4'b1000: begin cmd4_d = 4'b0110; s_upd_d = 1'b1; rn_valid_d = 1'b1; end
               default: undef_d = 1'b1;
            endcase
            src2_valid_d = !undef_d && !instr[25];
         end
         2'b01: begin
            if (op == 4'b0100) begin
               cmd4_d     = 4'b0010;
               rn_valid_d = 1'b1;
               if (s_bit) begin
                  mem_read_d = 1'b1;
                  wb_en_d    = 1'b1;
               end else begin
                  mem_write_d  = 1'b1;
                  src2_rd_d    = 1'b1;
                  src2_valid_d = 1'b1;
               end
            end else begin
               undef_d = 1'b1;
            end
         end
         2'b10:   branch_d = 1'b1;
         default: undef_d  = 1'b1;
      endcase
   end

   // Condition field against {N,Z,C,V}; code 1111 never passes.
   always_comb begin
      cond_pass = 1'b0;
      case (instr[31:28])
         4'b0000: cond_pass = flags[2];
         4'b0001: cond_pass = !flags[2];
         4'b0010: cond_pass = flags[1];
         4'b0011: cond_pass = !flags[1];
         4'b0100: cond_pass = flags[3];
         4'b0101: cond_pass = !flags[3];
         4'b0110: cond_pass = flags[0];
         4'b0111: cond_pass = !flags[0];
         4'b1000: cond_pass = flags[1] && !flags[2];
         4'b1001: cond_pass = !flags[1] || flags[2];
         4'b1010: cond_pass = flags[3] == flags[0];
         4'b1011: cond_pass = flags[3] != flags[0];
         4'b1100: cond_pass = !flags[2] && (flags[3] == flags[0]);
         4'b1101: cond_pass = flags[2] || (flags[3] != flags[0]);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   logic              out_valid_q;
   logic [CMD_W-1:0]  exe_cmd_q;
   logic              mem_read_q, mem_write_q, wb_en_q, branch_q, s_upd_q;
   logic              rn_valid_q, src2_valid_q, imm_q, undef_q;
   logic [REG_AW-1:0] rn_q, rd_q, src2_q;
   logic [11:0]       shift_op_q;
   logic [23:0]       imm24_q;
   logic [PC_W-1:0]   out_pc_q;
   logic [CNT_W-1:0]  squash_cnt_q, squash_cnt_d;
   logic              accept;

   assign in_ready = rst && !stall && !flush && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   // Flush and accept are mutually exclusive through in_ready, but both are summed anyway.
   logic [1:0]     sq_inc;
   logic [CNT_W:0] sq_sum;
   assign sq_inc = {1'b0, flush && out_valid_q} + {1'b0, accept && !cond_pass};
   assign sq_sum = {1'b0, squash_cnt_q} + (CNT_W+1)'(sq_inc);
   assign squash_cnt_d = (sq_sum > {1'b0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : sq_sum[CNT_W-1:0];

   always_ff @(posedge clk) begin
      // NOTE: synchronous active-low reset; non-blocking assignments keep every register sampling pre-edge values.
      if (!rst) begin
         out_valid_q  <= 1'b0;
         exe_cmd_q    <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         wb_en_q      <= 1'b0;
         branch_q     <= 1'b0;
         s_upd_q      <= 1'b0;
         rn_valid_q   <= 1'b0;
         src2_valid_q <= 1'b0;
         imm_q        <= 1'b0;
         undef_q      <= 1'b0;
         rn_q         <= '0;
         rd_q         <= '0;
         src2_q       <= '0;
         shift_op_q   <= '0;
         imm24_q      <= '0;
         out_pc_q     <= '0;
         squash_cnt_q <= '0;
      end else begin
         squash_cnt_q <= squash_cnt_d;
         if (flush) begin
            out_valid_q <= 1'b0;
         end else if (accept) begin
            out_valid_q  <= 1'b1;
            exe_cmd_q    <= CMD_W'(cmd4_d);
            mem_read_q   <= mem_read_d   && cond_pass;
            mem_write_q  <= mem_write_d  && cond_pass;
            wb_en_q      <= wb_en_d      && cond_pass;
            branch_q     <= branch_d     && cond_pass;
            s_upd_q      <= s_upd_d      && cond_pass;
            rn_valid_q   <= rn_valid_d   && cond_pass;
            src2_valid_q <= src2_valid_d && cond_pass;
            undef_q      <= undef_d      && cond_pass;
            imm_q        <= instr[25];
            rn_q         <= REG_AW'(instr[19:16]);
            rd_q         <= REG_AW'(instr[15:12]);
            src2_q       <= src2_rd_d ? REG_AW'(instr[15:12]) : REG_AW'(instr[3:0]);
            shift_op_q   <= instr[11:0];
            imm24_q      <= instr[23:0];
            out_pc_q     <= in_pc;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign exe_cmd    = exe_cmd_q;
   assign mem_read   = mem_read_q;
   assign mem_write  = mem_write_q;
   assign wb_en      = wb_en_q;
   assign branch     = branch_q;
   assign s_upd      = s_upd_q;
   assign rn_valid   = rn_valid_q;
   assign src2_valid = src2_valid_q;
   assign imm        = imm_q;
   assign undef      = undef_q;
   assign rn         = rn_q;
   assign rd         = rd_q;
   assign src2       = src2_q;
   assign shift_op   = shift_op_q;
   assign imm24      = imm24_q;
   assign out_pc     = out_pc_q;
   assign squash_cnt = squash_cnt_q;

endmodule

// File: tb/tb_arm_id_stage.sv
// Scoreboard bench for arm_id_stage: a reference model queues expected entries,
// a negedge monitor compares them as the DUT presents them.
module tb_arm_id_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] instr = '0;
   logic [31:0] in_pc = '0;
   logic [3:0]  flags = '0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid, mem_read, mem_write, wb_en, branch, s_upd;
   logic        rn_valid, src2_valid, imm, undef;
   logic [3:0]  exe_cmd, rn, rd, src2;
   logic [11:0] shift_op;
   logic [23:0] imm24;
   logic [31:0] out_pc;
   logic [15:0] squash_cnt;

   logic        s_in_ready, s_out_valid, s_mem_read, s_mem_write, s_wb_en, s_branch, s_s_upd;
   logic        s_rn_valid, s_src2_valid, s_imm, s_undef;
   logic [3:0]  s_exe_cmd, s_rn, s_rd, s_src2;
   logic [11:0] s_shift_op;
   logic [23:0] s_imm24;
   logic [31:0] s_out_pc;
   logic [1:0]  s_squash_cnt;

   always #5 clk = ~clk;

   arm_id_stage u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
      .in_pc(in_pc), .flags(flags), .stall(stall), .flush(flush), .out_ready(out_ready),
      .out_valid(out_valid), .exe_cmd(exe_cmd), .mem_read(mem_read), .mem_write(mem_write),
      .wb_en(wb_en), .branch(branch), .s_upd(s_upd), .rn_valid(rn_valid),
      .src2_valid(src2_valid), .imm(imm), .rn(rn), .rd(rd), .src2(src2),
      .shift_op(shift_op), .imm24(imm24), .out_pc(out_pc), .undef(undef),
      .squash_cnt(squash_cnt)
   );

   arm_id_stage #(.CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .instr(instr),
      .in_pc(in_pc), .flags(flags), .stall(stall), .flush(flush), .out_ready(out_ready),
      .out_valid(s_out_valid), .exe_cmd(s_exe_cmd), .mem_read(s_mem_read),
      .mem_write(s_mem_write), .wb_en(s_wb_en), .branch(s_branch), .s_upd(s_s_upd),
      .rn_valid(s_rn_valid), .src2_valid(s_src2_valid), .imm(s_imm), .rn(s_rn), .rd(s_rd),
      .src2(s_src2), .shift_op(s_shift_op), .imm24(s_imm24), .out_pc(s_out_pc),
      .undef(s_undef), .squash_cnt(s_squash_cnt)
   );

   typedef struct packed {
      logic [3:0]  cmd;
      logic        mr, mw, wb, br, su, rnv, s2v, im, ud;
      logic [3:0]  rn, rd, src2;
      logic [11:0] shop;
      logic [23:0] imm24;
      logic [31:0] pc;
   } entry_t;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Condition test: pairs of codes share a base predicate, odd codes invert it.
   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, base;
      {n, z, cy, v} = f;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy & !z;
         3'd5: base = (n == v);
         3'd6: base = !z & (n == v);
         default: base = 1'b1;
      endcase
      return c[0] ? !base : base;
   endfunction

   function automatic entry_t model(input logic [31:0] ins, input logic [31:0] pc,
                                    input logic [3:0] f, output logic failed);
      entry_t e;
      logic [3:0] op;
      logic known, writes, uses_rn;
      logic [3:0] cmd;
      e = '0;
      op = ins[24:21];
      e.im = ins[25]; e.rn = ins[19:16]; e.rd = ins[15:12]; e.src2 = ins[3:0];
      e.shop = ins[11:0]; e.imm24 = ins[23:0]; e.pc = pc;
      {known, cmd, writes, uses_rn} = 7'b0;
      case (op)
         4'hD: {known, cmd, writes, uses_rn} = {1'b1, 4'h1, 1'b1, 1'b0};
         4'hF: {known, cmd, writes, uses_rn} = {1'b1, 4'h9, 1'b1, 1'b0};
         4'h4: {known, cmd, writes, uses_rn} = {1'b1, 4'h2, 1'b1, 1'b1};
         4'h5: {known, cmd, writes, uses_rn} = {1'b1, 4'h3, 1'b1, 1'b1};
         4'h2: {known, cmd, writes, uses_rn} = {1'b1, 4'h4, 1'b1, 1'b1};
         4'h6: {known, cmd, writes, uses_rn} = {1'b1, 4'h5, 1'b1, 1'b1};
         4'h0: {known, cmd, writes, uses_rn} = {1'b1, 4'h6, 1'b1, 1'b1};
         4'hC: {known, cmd, writes, uses_rn} = {1'b1, 4'h7, 1'b1, 1'b1};
         4'h1: {known, cmd, writes, uses_rn} = {1'b1, 4'h8, 1'b1, 1'b1};
         4'hA: {known, cmd, writes, uses_rn} = {1'b1, 4'h4, 1'b0, 1'b1};
         4'h8: {known, cmd, writes, uses_rn} = {1'b1, 4'h6, 1'b0, 1'b1};
         default: ;
      endcase
      if (ins[27:26] == 2'b00 && known) begin
         e.cmd = cmd; e.wb = writes; e.su = writes ? ins[20] : 1'b1;
         e.rnv = uses_rn; e.s2v = !ins[25];
      end else if (ins[27:26] == 2'b01 && op == 4'b0100) begin
         e.cmd = 4'h2; e.rnv = 1'b1;
         if (ins[20]) begin e.mr = 1'b1; e.wb = 1'b1; end
         else begin e.mw = 1'b1; e.src2 = ins[15:12]; e.s2v = 1'b1; end
      end else if (ins[27:26] == 2'b10) begin
         e.br = 1'b1;
      end else begin
         e.ud = 1'b1;
      end
      failed = !cond_ok(ins[31:28], f);
      if (failed) {e.mr, e.mw, e.wb, e.br, e.su, e.rnv, e.s2v, e.ud} = '0;
      return e;
   endfunction

   entry_t exp_q[$];
   logic   exp_valid = 1'b0;
   logic   exp_zero  = 1'b0;
   logic   started   = 1'b0;
   int     sq        = 0;

   // Reference model: advances at the active edge using the inputs held over the cycle.
   always @(posedge clk) begin
      logic acc, failed;
      entry_t e;
      started = 1'b1;
      acc = in_valid && rst && !stall && !flush && (!exp_valid || out_ready);
      if (!rst) begin
         exp_q.delete(); exp_valid = 1'b0; exp_zero = 1'b1; sq = 0;
      end else if (flush) begin
         if (exp_valid) sq++;
         exp_valid = 1'b0;
      end else if (acc) begin
         e = model(instr, in_pc, flags, failed);
         exp_q.push_back(e);
         if (failed) sq++;
         exp_valid = 1'b1; exp_zero = 1'b0;
      end else if (out_ready) begin
         exp_valid = 1'b0;
      end
   end

   entry_t got;
   assign got = '{cmd: exe_cmd, mr: mem_read, mw: mem_write, wb: wb_en, br: branch, su: s_upd,
                  rnv: rn_valid, s2v: src2_valid, im: imm, ud: undef, rn: rn, rd: rd,
                  src2: src2, shop: shift_op, imm24: imm24, pc: out_pc};

   always @(negedge clk) begin
      entry_t e;
      if (started) begin
         check("in_ready", in_ready, rst && !stall && !flush && (!exp_valid || out_ready));
         check("out_valid", out_valid, exp_valid);
         check("squash_cnt", squash_cnt, sq[15:0]);
         check("squash_sat", s_squash_cnt, (sq > 3) ? 3 : sq);
         check("sat_mirror",
               {s_in_ready, s_out_valid, s_exe_cmd, s_mem_read, s_mem_write, s_wb_en, s_branch,
                s_s_upd, s_rn_valid, s_src2_valid, s_imm, s_undef, s_rn, s_rd, s_src2,
                s_shift_op, s_imm24, s_out_pc},
               {in_ready, out_valid, got});
         if (exp_zero) check("reset_clear", {out_valid, got, squash_cnt}, '0);
         if (exp_valid) begin
            if (exp_q.size() == 0) begin
               check("queue_underflow", 1, 0);
            end else begin
               e = exp_q[0];
               check("entry", got, e);
               if (out_ready || flush || !rst) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic drive(input logic v, input logic [31:0] ins, input logic [3:0] f,
                        input logic st, input logic fl, input logic ordy);
      in_valid = v; instr = ins; flags = f; stall = st; flush = fl; out_ready = ordy;
      @(posedge clk);
      #1;
      in_pc = in_pc + 32'd4;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] ins;
      ins = $urandom;
      case ($urandom_range(0, 4))
         0, 1: ins[27:26] = 2'b00;
         2: begin ins[27:26] = 2'b01; ins[24:21] = 4'b0100; end
         3: ins[27:26] = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b11;
         default: ins[27:26] = 2'b10;
      endcase
      if ($urandom_range(0, 1) != 0) ins[31:28] = 4'hE;
      return ins;
   endfunction

   initial begin
      in_pc = 32'h0000_1000;
      drive(0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 1);
      rst = 1'b1;
      drive(1, 32'hE082_1003, 4'b0000, 0, 0, 1);  // ADD R1,R2,R3
      drive(1, 32'hE492_1004, 4'b0000, 0, 0, 1);  // LDR R1,[R2]
      drive(1, 32'hE482_1004, 4'b0000, 0, 0, 1);  // STR R1,[R2]
      drive(1, 32'h1082_1003, 4'b0100, 0, 0, 1);  // ADDNE with Z=1 fails
      drive(1, 32'h0082_1003, 4'b0100, 0, 0, 1);  // ADDEQ with Z=1 passes
      drive(1, 32'hE1A0_1002, 4'b0000, 0, 0, 0);  // MOV, then held back-pressure
      repeat (3) drive(1, 32'hE052_1003, 4'b0000, 0, 0, 0);
      drive(1, 32'hE052_1003, 4'b0000, 1, 0, 1);  // stall drains the held entry
      drive(0, 0, 4'b0000, 0, 0, 1);
      repeat (5) begin
         drive(1, 32'hE152_0003, 4'b0000, 0, 0, 0);
         drive(1, 32'hEA00_0010, 4'b0000, 0, 1, 0);
      end
      drive(1, 32'hEC00_0000, 4'b0000, 0, 0, 1);  // mode 11: undefined
      drive(1, 32'hF082_1003, 4'b0000, 0, 0, 1);  // cond 1111 never passes
      drive(1, 32'hE282_1003, 4'b0000, 0, 0, 1);
      rst = 1'b0;
      drive(1, 32'hE082_1003, 4'b0000, 1, 1, 0);
      rst = 1'b1;
      drive(0, 0, 4'b0000, 0, 0, 1);
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) rst = 1'b0;
         else rst = 1'b1;
         drive($urandom_range(0, 3) != 0, rand_instr(), 4'($urandom),
               $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
               $urandom_range(0, 3) != 0);
      end
      rst = 1'b1;
      repeat (3) drive(0, 0, 4'b0000, 0, 0, 1);
      check("drain_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
